seq_det_ctrl: RTL and testbench

//  Sequencer for a bit-serial sequence detector (ports clk/rst/in/out).

---
 rtl/seq_det_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: sequencer for a bit-serial sequence detector.
// Latches a word, clears the detector, shifts bits MSB-first, counts hits.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    job request, sampled only in IDLE
//   word     bits to scan, sent from word[WORD_W-1] downward
//   len      bits to send, clamped to WORD_W
//   busy     high in every state except IDLE
//   done     one-cycle pulse in DONE
//   hit_cnt  saturating hit count of the last job
//   det_rst  registered active-low detector clear
//   det_in   registered serial bit to the detector
//   det_out  detector output
//   hit_map  per-bit hit flags (only with SEQ_CTRL_HITMAP_EN defined)
//
// Optional feature macro: SEQ_CTRL_HITMAP_EN adds the hit_map output.

module seq_det_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5,
  parameter int LAT    = 1,
  parameter int LEN_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_cnt,
`ifdef SEQ_CTRL_HITMAP_EN
  output logic [WORD_W-1:0] hit_map,
`endif
  output logic              det_rst,
  output logic              det_in,
  input  logic              det_out
);

  localparam int PW = (LAT > 0) ? LAT : 1;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]  bits_q, bits_d;
  logic [LEN_W-1:0]  len_c;
  logic [DW-1:0]     drain_q, drain_d;
  logic              vld_q, vld_d;
  logic [PW-1:0]     pipe_q, pipe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              det_rst_q, det_rst_d;
  logic              det_in_q, det_in_d;
  logic              tap;
  logic              hit;
`ifdef SEQ_CTRL_HITMAP_EN
  logic [WORD_W-1:0] map_q, map_d;
  logic [WORD_W-1:0] mask_q, mask_d;
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bits_d    = bits_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    det_in_d  = 1'b0;
    det_rst_d = 1'b1;
    pipe_d    = '0;
`ifdef SEQ_CTRL_HITMAP_EN
    map_d     = map_q;
    mask_d    = mask_q;
`endif

    len_c = (len > LEN_MAX) ? LEN_MAX : len;

    // vld_q marks a real bit on det_in; the tap lines it up with det_out
    pipe_d[0] = vld_q;
    for (int i = 1; i < PW; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    tap = (LAT == 0) ? vld_q : pipe_q[PW-1];
    hit = tap & det_out;

    if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef SEQ_CTRL_HITMAP_EN
    if (tap) begin
      mask_d = mask_q >> 1;
    end
    if (hit) begin
      map_d = map_q | mask_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d   = word;
          bits_d = len_c;
          cnt_d  = '0;
`ifdef SEQ_CTRL_HITMAP_EN
          map_d  = '0;
          mask_d = {1'b1, {(WORD_W-1){1'b0}}};
`endif
          if (len_c == '0) begin
            state_d = DONE;
          end else begin
            state_d   = CLEAR;
            det_rst_d = 1'b0;
          end
        end
      end
      CLEAR: begin
        state_d  = SHIFT;
        det_in_d = sr_q[WORD_W-1];
        vld_d    = 1'b1;
        sr_d     = sr_q << 1;
        bits_d   = bits_q - 1'b1;
      end
      SHIFT: begin
        if (bits_q != '0) begin
          det_in_d = sr_q[WORD_W-1];
          vld_d    = 1'b1;
          sr_d     = sr_q << 1;
          bits_d   = bits_q - 1'b1;
        end else if (LAT == 0) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
          drain_d = DW'(LAT - 1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bits_q    <= '0;
      drain_q   <= '0;
      vld_q     <= 1'b0;
      pipe_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_rst_q <= 1'b0;
      det_in_q  <= 1'b0;
`ifdef SEQ_CTRL_HITMAP_EN
      map_q     <= '0;
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bits_q    <= bits_d;
      drain_q   <= drain_d;
      vld_q     <= vld_d;
      pipe_q    <= pipe_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      det_rst_q <= det_rst_d;
      det_in_q  <= det_in_d;
`ifdef SEQ_CTRL_HITMAP_EN
      map_q     <= map_d;
      mask_q    <= mask_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit_cnt = cnt_q;
  assign det_rst = det_rst_q;
  assign det_in  = det_in_q;
`ifdef SEQ_CTRL_HITMAP_EN
  assign hit_map = map_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: bench for seq_det_ctrl with a "1011" Moore detector.
// Two instances: CNT_W=5 (a) and CNT_W=2 (b) share all stimulus.

module tb_seq_det_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] word;
  logic [4:0]  len;

  logic        busy_a, done_a, det_rst_a, det_in_a, det_out_a;
  logic [4:0]  hit_cnt_a;
  logic        busy_b, done_b, det_rst_b, det_in_b, det_out_b;
  logic [1:0]  hit_cnt_b;
`ifdef SEQ_CTRL_HITMAP_EN
  logic [15:0] hit_map_a, hit_map_b;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cnt5;
    int          cnt2;
    logic [15:0] map;
    logic [15:0] bits;
    int          l;
  } exp_t;

  typedef struct {
    int          lat;
    logic [15:0] bits;
    int          cnt_a;
    int          cnt_b;
    logic [15:0] map_a;
    logic        done_next;
    int          cnt_start;
    int          cnt_after;
    int          clears;
  } obs_t;

  exp_t sb[$];

  seq_det_ctrl #(.WORD_W(16), .CNT_W(5), .LAT(1)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .word    (word),
    .len     (len),
    .busy    (busy_a),
    .done    (done_a),
    .hit_cnt (hit_cnt_a),
`ifdef SEQ_CTRL_HITMAP_EN
    .hit_map (hit_map_a),
`endif
    .det_rst (det_rst_a),
    .det_in  (det_in_a),
    .det_out (det_out_a)
  );

  seq_det_ctrl #(.WORD_W(16), .CNT_W(2), .LAT(1)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .word    (word),
    .len     (len),
    .busy    (busy_b),
    .done    (done_b),
    .hit_cnt (hit_cnt_b),
`ifdef SEQ_CTRL_HITMAP_EN
    .hit_map (hit_map_b),
`endif
    .det_rst (det_rst_b),
    .det_in  (det_in_b),
    .det_out (det_out_b)
  );

  // overlapping "1011" Moore detectors, one registered stage
  logic [3:0] ha, hb;

  always_ff @(posedge clk or negedge det_rst_a) begin
    if (!det_rst_a) begin
      ha <= 4'd0;
      det_out_a <= 1'b0;
    end else begin
      ha <= {ha[2:0], det_in_a};
      det_out_a <= ({ha[2:0], det_in_a} == 4'b1011);
    end
  end

  always_ff @(posedge clk or negedge det_rst_b) begin
    if (!det_rst_b) begin
      hb <= 4'd0;
      det_out_b <= 1'b0;
    end else begin
      hb <= {hb[2:0], det_in_b};
      det_out_b <= ({hb[2:0], det_in_b} == 4'b1011);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int ref_hits(input logic [15:0] w, input int l,
                                  output logic [15:0] m);
    logic [3:0] h;
    int n;
    h = 4'd0;
    m = 16'd0;
    n = 0;
    for (int k = 0; k < l; k++) begin
      h = {h[2:0], w[15-k]};
      if (h == 4'b1011) begin
        n++;
        m[15-k] = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic do_job(input logic [15:0] w, input int l_in,
                        output obs_t o);
    exp_t e;
    logic [15:0] m;
    logic [15:0] mk;
    int h, lc, n;
    lc = (l_in > 16) ? 16 : l_in;
    h = ref_hits(w, lc, m);
    mk = 16'hFFFF >> lc;
    e.cnt5 = (h > 31) ? 31 : h;
    e.cnt2 = (h > 3) ? 3 : h;
    e.map  = m;
    e.bits = (lc == 0) ? 16'd0 : (w & ~mk);
    e.l    = lc;
    sb.push_back(e);
    @(negedge clk);
    word  = w;
    len   = 5'(l_in);
    start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    o.cnt_start = int'(hit_cnt_a);
    o.bits = 16'd0;
    o.lat = -1;
    o.clears = 0;
    o.map_a = 16'd0;
    while (n < 100) begin
      if (!det_rst_a) o.clears++;
      if (n >= 2 && n <= lc + 1) o.bits[17-n] = det_in_a;
      if (done_a) begin
        o.lat = n;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    o.cnt_a = int'(hit_cnt_a);
    o.cnt_b = int'(hit_cnt_b);
`ifdef SEQ_CTRL_HITMAP_EN
    o.map_a = hit_map_a;
`endif
    @(negedge clk);
    o.done_next = done_a;
    repeat (2) @(negedge clk);
    o.cnt_after = int'(hit_cnt_a);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    word = 16'd0;
    len = 5'd0;
    #22;
    checks += 5;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", busy_a);
    end
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL rst_done: got %b want 0", done_a);
    end
    if (hit_cnt_a !== 5'd0) begin
      errors++; $display("FAIL rst_cnt: got %0d want 0", hit_cnt_a);
    end
    if (det_in_a !== 1'b0) begin
      errors++; $display("FAIL rst_det_in: got %b want 0", det_in_a);
    end
    if (det_rst_a !== 1'b0) begin
      errors++; $display("FAIL rst_det_rst: got %b want 0", det_rst_a);
    end
    #8;
    rst = 1'b1;
    #1;
    checks++;
    if (det_rst_a !== 1'b0) begin
      errors++; $display("FAIL rst_rel_det_rst: got %b want 0", det_rst_a);
    end
    @(negedge clk);
    checks += 2;
    if (det_rst_a !== 1'b1) begin
      errors++; $display("FAIL rst_edge_det_rst: got %b want 1", det_rst_a);
    end
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL rst_edge_busy: got %b want 0", busy_a);
    end
  endtask

  task automatic test_basic();
    obs_t o;
    exp_t e;
    do_job(16'hB6C0, 10, o);
    e = sb.pop_front();
    checks += 8;
    if (o.lat !== e.l + 3) begin
      errors++; $display("FAIL basic_lat: got %0d want %0d", o.lat, e.l + 3);
    end
    if (o.bits !== e.bits) begin
      errors++; $display("FAIL basic_bits: got %h want %h", o.bits, e.bits);
    end
    if (o.cnt_a !== e.cnt5) begin
      errors++; $display("FAIL basic_cnt: got %0d want %0d", o.cnt_a, e.cnt5);
    end
    if (o.cnt_b !== e.cnt2) begin
      errors++; $display("FAIL basic_cnt2: got %0d want %0d", o.cnt_b, e.cnt2);
    end
    if (o.done_next !== 1'b0) begin
      errors++; $display("FAIL basic_done_w: got %b want 0", o.done_next);
    end
    if (o.cnt_start !== 0) begin
      errors++; $display("FAIL basic_clr: got %0d want 0", o.cnt_start);
    end
    if (o.cnt_after !== e.cnt5) begin
      errors++; $display("FAIL basic_hold: got %0d want %0d", o.cnt_after, e.cnt5);
    end
    if (o.clears !== 1) begin
      errors++; $display("FAIL basic_clear: got %0d want 1", o.clears);
    end
`ifdef SEQ_CTRL_HITMAP_EN
    checks++;
    if (o.map_a !== e.map) begin
      errors++; $display("FAIL basic_map: got %h want %h", o.map_a, e.map);
    end
`endif
  endtask

  task automatic test_zero_len();
    obs_t o;
    exp_t e;
    do_job(16'hFFFF, 0, o);
    e = sb.pop_front();
    checks += 4;
    if (o.lat !== 1) begin
      errors++; $display("FAIL zero_lat: got %0d want 1", o.lat);
    end
    if (o.cnt_a !== e.cnt5) begin
      errors++; $display("FAIL zero_cnt: got %0d want %0d", o.cnt_a, e.cnt5);
    end
    if (o.clears !== 0) begin
      errors++; $display("FAIL zero_clear: got %0d want 0", o.clears);
    end
    if (o.done_next !== 1'b0) begin
      errors++; $display("FAIL zero_done_w: got %b want 0", o.done_next);
    end
  endtask

  task automatic test_saturate();
    obs_t o;
    exp_t e;
    do_job(16'hB6DB, 16, o);
    e = sb.pop_front();
    checks += 4;
    if (o.cnt_b !== 3) begin
      errors++; $display("FAIL sat_cnt2: got %0d want 3", o.cnt_b);
    end
    if (o.cnt_a !== 5) begin
      errors++; $display("FAIL sat_cnt5: got %0d want 5", o.cnt_a);
    end
    if (o.bits !== e.bits) begin
      errors++; $display("FAIL sat_bits: got %h want %h", o.bits, e.bits);
    end
    if (o.lat !== 19) begin
      errors++; $display("FAIL sat_lat: got %0d want 19", o.lat);
    end
  endtask

  task automatic test_clamp();
    obs_t o;
    exp_t e;
    do_job(16'hB6DB, 20, o);
    e = sb.pop_front();
    checks += 3;
    if (o.lat !== 19) begin
      errors++; $display("FAIL clamp_lat: got %0d want 19", o.lat);
    end
    if (o.cnt_a !== e.cnt5) begin
      errors++; $display("FAIL clamp_cnt: got %0d want %0d", o.cnt_a, e.cnt5);
    end
    if (o.bits !== 16'hB6DB) begin
      errors++; $display("FAIL clamp_bits: got %h want b6db", o.bits);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    word = 16'hB6C0;
    len = 5'd10;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    word = 16'h0000;
    len = 5'd16;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks += 3;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b want 1", busy_a);
    end
    if (det_in_a !== 1'b1) begin
      errors++; $display("FAIL abort_bit6: got %b want 1", det_in_a);
    end
    if (hit_cnt_a !== 5'd1) begin
      errors++; $display("FAIL abort_part: got %0d want 1", hit_cnt_a);
    end
    rst = 1'b0;
    #1;
    checks += 4;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL abort_rst_busy: got %b want 0", busy_a);
    end
    if (hit_cnt_a !== 5'd0) begin
      errors++; $display("FAIL abort_rst_cnt: got %0d want 0", hit_cnt_a);
    end
    if (det_in_a !== 1'b0) begin
      errors++; $display("FAIL abort_rst_in: got %b want 0", det_in_a);
    end
    if (det_rst_a !== 1'b0) begin
      errors++; $display("FAIL abort_rst_det: got %b want 0", det_rst_a);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got %b want 0", busy_a);
    end
    if (hit_cnt_a !== 5'd0) begin
      errors++; $display("FAIL abort_cnt0: got %0d want 0", hit_cnt_a);
    end
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL abort_done: got %b want 0", done_a);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int lat1;
    int lat2;
    @(negedge clk);
    word = 16'hB000;
    len = 5'd4;
    start = 1'b1;
    @(posedge clk);
    n = 1;
    lat1 = -1;
    @(negedge clk);
    while (n < 50) begin
      if (done_a) begin
        lat1 = n;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks += 3;
    if (lat1 !== 7) begin
      errors++; $display("FAIL b2b_lat1: got %0d want 7", lat1);
    end
    if (hit_cnt_a !== 5'd1) begin
      errors++; $display("FAIL b2b_cnt1: got %0d want 1", hit_cnt_a);
    end
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_busy_done: got %b want 1", busy_a);
    end
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got %b want 0", busy_a);
    end
    if (hit_cnt_a !== 5'd1) begin
      errors++; $display("FAIL b2b_hold: got %0d want 1", hit_cnt_a);
    end
    @(posedge clk);
    n = 1;
    lat2 = -1;
    @(negedge clk);
    start = 1'b0;
    checks += 2;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got %b want 1", busy_a);
    end
    if (hit_cnt_a !== 5'd0) begin
      errors++; $display("FAIL b2b_clr: got %0d want 0", hit_cnt_a);
    end
    while (n < 50) begin
      if (done_a) begin
        lat2 = n;
        break;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks += 2;
    if (lat2 !== 7) begin
      errors++; $display("FAIL b2b_lat2: got %0d want 7", lat2);
    end
    if (hit_cnt_a !== 5'd1) begin
      errors++; $display("FAIL b2b_cnt2: got %0d want 1", hit_cnt_a);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [15:0] w;
    int l;
    int want_lat;
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      l = $urandom_range(0, 20);
      do_job(w, l, o);
      e = sb.pop_front();
      want_lat = (e.l == 0) ? 1 : e.l + 3;
      checks += 4;
      if (o.lat !== want_lat) begin
        errors++; $display("FAIL rnd_lat: got %0d want %0d", o.lat, want_lat);
      end
      if (o.bits !== e.bits) begin
        errors++; $display("FAIL rnd_bits: got %h want %h", o.bits, e.bits);
      end
      if (o.cnt_a !== e.cnt5) begin
        errors++; $display("FAIL rnd_cnt: got %0d want %0d", o.cnt_a, e.cnt5);
      end
      if (o.cnt_b !== e.cnt2) begin
        errors++; $display("FAIL rnd_cnt2: got %0d want %0d", o.cnt_b, e.cnt2);
      end
`ifdef SEQ_CTRL_HITMAP_EN
      checks++;
      if (o.map_a !== e.map) begin
        errors++; $display("FAIL rnd_map: got %h want %h", o.map_a, e.map);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_saturate();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
